// File: rtl/sram_fifo_arbiter_pkg.sv
// ============================================================================
// sram_fifo_arbiter_pkg : shared state encoding and default sizes
// Revision: 1.0
// ============================================================================
`default_nettype none

package sram_fifo_arbiter_pkg;

    localparam int c_DEFAULT_BITS  = 8;
    localparam int c_DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// rr_arbiter2 : two-input round-robin arbiter, combinational grant
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic i_reqA,
    input  logic i_reqB,
    output logic o_gntA,
    output logic o_gntB
);

    // Set when B was granted most recently; starts at B so A wins the first conflict.
    logic r_lastB;

    always_comb begin
        o_gntA = i_reqA && (!i_reqB || r_lastB);
        o_gntB = i_reqB && !o_gntA;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lastB <= 1'b1;
        end else if (o_gntA || o_gntB) begin
            r_lastB <= o_gntB;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_fifo_arbiter.sv
// ============================================================================
// sram_fifo_arbiter : two-requester arbiter in front of a shared SRAM FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_fifo_arbiter
    import sram_fifo_arbiter_pkg::*;
#(
    parameter int BITS  = c_DEFAULT_BITS,
    parameter int DEPTH = c_DEFAULT_DEPTH,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_wr_req,
    input  logic            b_wr_req,
    input  logic            a_rd_req,
    input  logic            b_rd_req,
    input  logic [BITS-1:0] a_wdata,
    input  logic [BITS-1:0] b_wdata,
    output logic            a_gnt,
    output logic            b_gnt,
    output logic            a_rvalid,
    output logic            b_rvalid,
    output logic [BITS-1:0] rdata,
    output logic            fifo_read,
    output logic            fifo_write,
    output logic [BITS-1:0] fifo_wdata,
    input  logic [BITS-1:0] fifo_rdata,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count
);

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic            r_aGnt;
    logic            r_bGnt;
    logic            r_aRvalid;
    logic            r_bRvalid;
    logic [BITS-1:0] r_wdata;

    logic            w_notEmpty;
    logic            w_notFull;
    logic            w_aRd;
    logic            w_aWr;
    logic            w_bRd;
    logic            w_bWr;
    logic            w_selA;
    logic            w_selB;
    logic            w_issueRd;
    logic            w_issueWr;
    logic [BITS-1:0] w_winWdata;

    // r_count already reflects every operation granted so far, so it is the
    // right occupancy to judge eligibility against.
    assign w_notEmpty = (r_count != '0);
    assign w_notFull  = (r_count != CW'(DEPTH));

    assign w_aRd = a_rd_req && w_notEmpty;
    assign w_aWr = a_wr_req && w_notFull;
    assign w_bRd = b_rd_req && w_notEmpty;
    assign w_bWr = b_wr_req && w_notFull;

    rr_arbiter2 u_rrArbiter (
        .clk    (clk),
        .rst    (rst),
        .i_reqA (w_aRd || w_aWr),
        .i_reqB (w_bRd || w_bWr),
        .o_gntA (w_selA),
        .o_gntB (w_selB)
    );

    // A requester with both operations eligible performs its read.
    assign w_issueRd  = (w_selA && w_aRd) || (w_selB && w_bRd);
    assign w_issueWr  = (w_selA && !w_aRd && w_aWr) || (w_selB && !w_bRd && w_bWr);
    assign w_winWdata = w_selA ? a_wdata : b_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_aGnt    <= 1'b0;
            r_bGnt    <= 1'b0;
            r_aRvalid <= 1'b0;
            r_bRvalid <= 1'b0;
            r_wdata   <= '0;
        end else begin
            r_aGnt    <= w_selA;
            r_bGnt    <= w_selB;
            r_aRvalid <= r_aGnt && (r_state == RD);
            r_bRvalid <= r_bGnt && (r_state == RD);
            if (w_issueWr) begin
                r_state <= WR;
                r_count <= r_count + 1'b1;
                r_wdata <= w_winWdata;
            end else if (w_issueRd) begin
                r_state <= RD;
                r_count <= r_count - 1'b1;
            end else begin
                r_state <= IDLE;
            end
        end
    end

    assign a_gnt      = r_aGnt;
    assign b_gnt      = r_bGnt;
    assign a_rvalid   = r_aRvalid;
    assign b_rvalid   = r_bRvalid;
    assign rdata      = fifo_rdata;
    assign fifo_write = (r_state == WR);
    assign fifo_read  = (r_state == RD);
    assign fifo_wdata = r_wdata;
    assign count      = r_count;
    assign full       = (r_count == CW'(DEPTH));
    assign empty      = (r_count == '0);

endmodule

`default_nettype wire
